// File: rtl/bridge_interco_pkg.sv
// Shared definitions for the L2/TCDM bridge crossbar.
//   - Default channel widths used by the request block and its interface.
//   - cnt_width(): width of a counter that must hold values 0..max inclusive.
package bridge_interco_pkg;

  localparam int unsigned DefaultAddrWidth = 32;
  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultAuxWidth  = 32;

  function automatic int unsigned cnt_width(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/request_block_rr_bridge_if.sv
// Bus bundle for request_block_rr_bridge.
// Signal names are relative to the bridge: *_i are driven into the bridge, *_o come out of it.
//   Master side (N channels): data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i,
//                             data_ID_i, data_aux_i -> data_gnt_o; data_r_valid_o
//   Slave side (1 channel):   data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
//                             data_ID_o, data_aux_o; data_gnt_i, data_r_valid_i, data_r_ID_i
// Modport slave is the bridge's own view; modport master is the surrounding environment.
interface request_block_rr_bridge_if
  import bridge_interco_pkg::*;
#(
  parameter int unsigned N_MASTER   = 16,
  parameter int unsigned ADDR_WIDTH = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned AUX_WIDTH  = DefaultAuxWidth,
  parameter int unsigned ID_WIDTH   = N_MASTER
);

  logic [N_MASTER-1:0]            data_req_i;
  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]            data_wen_i;
  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i;
  logic [N_MASTER*AUX_WIDTH-1:0]  data_aux_i;
  logic [N_MASTER-1:0]            data_gnt_o;

  logic                           data_req_o;
  logic [ADDR_WIDTH-1:0]          data_add_o;
  logic                           data_wen_o;
  logic [DATA_WIDTH-1:0]          data_wdata_o;
  logic [BE_WIDTH-1:0]            data_be_o;
  logic [ID_WIDTH-1:0]            data_ID_o;
  logic [AUX_WIDTH-1:0]           data_aux_o;
  logic                           data_gnt_i;

  logic                           data_r_valid_i;
  logic [ID_WIDTH-1:0]            data_r_ID_i;
  logic [N_MASTER-1:0]            data_r_valid_o;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i,
    output data_gnt_o,
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o,
    input  data_gnt_i, data_r_valid_i, data_r_ID_i,
    output data_r_valid_o
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i, data_aux_i,
    input  data_gnt_o,
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o,
    output data_gnt_i, data_r_valid_i, data_r_ID_i,
    input  data_r_valid_o
  );

endinterface

// File: rtl/rr_arb_bridge.sv
// Round-robin priority search for any N (no power-of-two padding).
//   req_i : request vector
//   ptr_i : index where the search starts (wraps modulo N)
//   gnt_o : one-hot winner, zero when no request
// The pointer register lives in the parent.
module rr_arb_bridge #(
  parameter int unsigned N        = 4,
  parameter int unsigned PtrWidth = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req_i,
  input  logic [PtrWidth-1:0] ptr_i,
  output logic [N-1:0]        gnt_o
);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] dbl_first;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = (i >= 32'(ptr_i));
    end
  end

  // Low half holds requests at or above ptr, high half all requests: the lowest set bit of the
  // concatenation is the first requester found when scanning from ptr with wrap-around.
  assign dbl       = {req_i, req_i & mask};
  assign dbl_first = dbl & (-dbl);
  assign gnt_o     = dbl_first[N-1:0] | dbl_first[2*N-1:N];

endmodule

// File: rtl/request_block_rr_bridge.sv
// N-master to one-slave request block for the bridge crossbar.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : master-side request channels, slave-side request channel, response routing
//   err_o      : sticky, set by a response to a master with nothing outstanding
// Fair round-robin arbitration over masters that are below their outstanding limit, optional
// one-entry registered output slice (OUT_REG=1), responses routed back by one-hot ID.
module request_block_rr_bridge
  import bridge_interco_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DefaultAddrWidth,
  parameter int unsigned DATA_WIDTH      = DefaultDataWidth,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned AUX_WIDTH       = DefaultAuxWidth,
  parameter int unsigned N_MASTER        = 16,
  parameter int unsigned ID_WIDTH        = N_MASTER,
  parameter int unsigned OUT_REG         = 1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  request_block_rr_bridge_if.slave  bus,
  output logic                      err_o
);

  localparam int unsigned PtrWidth = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int unsigned CntWidth = cnt_width(MAX_OUTSTANDING);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MAX_OUTSTANDING);

  logic [PtrWidth-1:0] ptr_q, ptr_d;
  logic [CntWidth-1:0] cnt_q [N_MASTER];
  logic [CntWidth-1:0] cnt_d [N_MASTER];
  logic                err_d;

  logic [N_MASTER-1:0] eligible, winner, gnt, rvalid;
  logic                slot_free;

  logic [ADDR_WIDTH-1:0] mux_add;
  logic                  mux_wen;
  logic [DATA_WIDTH-1:0] mux_wdata;
  logic [BE_WIDTH-1:0]   mux_be;
  logic [ID_WIDTH-1:0]   mux_id;
  logic [AUX_WIDTH-1:0]  mux_aux;

  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      eligible[k] = bus.data_req_i[k] && (cnt_q[k] < CntMax);
    end
  end

  rr_arb_bridge #(
    .N        (N_MASTER),
    .PtrWidth (PtrWidth)
  ) u_arb (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .gnt_o (winner)
  );

  // One-hot AND-OR payload select, no index decode on the data path.
  always_comb begin
    mux_add   = '0;
    mux_wen   = 1'b0;
    mux_wdata = '0;
    mux_be    = '0;
    mux_id    = '0;
    mux_aux   = '0;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      mux_add   |= bus.data_add_i[k*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{winner[k]}};
      mux_wen   |= bus.data_wen_i[k] & winner[k];
      mux_wdata |= bus.data_wdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{winner[k]}};
      mux_be    |= bus.data_be_i[k*BE_WIDTH +: BE_WIDTH] & {BE_WIDTH{winner[k]}};
      mux_id    |= bus.data_ID_i[k*ID_WIDTH +: ID_WIDTH] & {ID_WIDTH{winner[k]}};
      mux_aux   |= bus.data_aux_i[k*AUX_WIDTH +: AUX_WIDTH] & {AUX_WIDTH{winner[k]}};
    end
  end

  assign gnt                = winner & {N_MASTER{slot_free & rst_n}};
  assign bus.data_gnt_o     = gnt;
  assign rvalid             = {N_MASTER{bus.data_r_valid_i}} & bus.data_r_ID_i;
  assign bus.data_r_valid_o = rvalid;

  // Next search starts just after the granted master; N_MASTER=1 keeps ptr at 0.
  always_comb begin
    ptr_d = ptr_q;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      if (gnt[k]) ptr_d = (k == N_MASTER - 1) ? '0 : PtrWidth'(k + 1);
    end
  end

  always_comb begin
    err_d = err_o;
    for (int unsigned k = 0; k < N_MASTER; k++) begin
      cnt_d[k] = cnt_q[k];
      if (gnt[k] && !rvalid[k]) begin
        cnt_d[k] = cnt_q[k] + CntWidth'(1);
      end else if (rvalid[k] && !gnt[k]) begin
        if (cnt_q[k] == '0) err_d = 1'b1;
        else                cnt_d[k] = cnt_q[k] - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      err_o <= 1'b0;
      for (int unsigned k = 0; k < N_MASTER; k++) cnt_q[k] <= '0;
    end else begin
      ptr_q <= ptr_d;
      err_o <= err_d;
      cnt_q <= cnt_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  vld_q;
    logic [ADDR_WIDTH-1:0] add_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_WIDTH-1:0]   be_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [AUX_WIDTH-1:0]  aux_q;

    // The slot can take a new entry in the same cycle the slave drains the old one.
    assign slot_free = !vld_q || bus.data_gnt_i;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q   <= 1'b0;
        add_q   <= '0;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        be_q    <= '0;
        id_q    <= '0;
        aux_q   <= '0;
      end else if (|gnt) begin
        vld_q   <= 1'b1;
        add_q   <= mux_add;
        wen_q   <= mux_wen;
        wdata_q <= mux_wdata;
        be_q    <= mux_be;
        id_q    <= mux_id;
        aux_q   <= mux_aux;
      end else if (bus.data_gnt_i) begin
        vld_q   <= 1'b0;
      end
    end

    assign bus.data_req_o   = vld_q;
    assign bus.data_add_o   = add_q;
    assign bus.data_wen_o   = wen_q;
    assign bus.data_wdata_o = wdata_q;
    assign bus.data_be_o    = be_q;
    assign bus.data_ID_o    = id_q;
    assign bus.data_aux_o   = aux_q;
  end else begin : g_out_comb
    assign slot_free        = bus.data_gnt_i;
    assign bus.data_req_o   = rst_n & (|eligible);
    assign bus.data_add_o   = mux_add;
    assign bus.data_wen_o   = mux_wen;
    assign bus.data_wdata_o = mux_wdata;
    assign bus.data_be_o    = mux_be;
    assign bus.data_ID_o    = mux_id;
    assign bus.data_aux_o   = mux_aux;
  end

endmodule

// File: tb/tb_request_block_rr_bridge.sv
module tb_request_block_rr_bridge;

  localparam int N    = 5;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int XW   = 32;
  localparam int MAXO = 2;

  typedef struct {
    logic [AW-1:0] add;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [N-1:0]  id;
    logic [XW-1:0] aux;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  logic err;

  always #5 clk = ~clk;

  request_block_rr_bridge_if #(
    .N_MASTER   (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BE_WIDTH   (BW),
    .AUX_WIDTH  (XW),
    .ID_WIDTH   (N)
  ) bus ();

  request_block_rr_bridge #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .BE_WIDTH        (BW),
    .AUX_WIDTH       (XW),
    .N_MASTER        (N),
    .ID_WIDTH        (N),
    .OUT_REG         (1),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err_o (err)
  );

  // Stimulus state
  logic         rst_req;
  logic         m_req [N];
  req_t         m_pay [N];
  logic         slv_gnt;
  logic         rv;
  logic [N-1:0] rid;

  // Reference model state
  req_t exp_q[$];     // requests granted to a master, not yet taken by the slave
  int   m_cnt [N];    // in-flight requests per master
  int   m_ptr;
  bit   m_err;
  int   glog[$];      // masters granted, in order
  int   rfifo[$];     // masters owed a response
  int   hs_cnt;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic new_payload(input int k);
    m_pay[k].add   = $urandom;
    m_pay[k].wen   = 1'($urandom_range(0, 1));
    m_pay[k].wdata = $urandom;
    m_pay[k].be    = BW'($urandom_range(0, 15));
    m_pay[k].id    = N'(1) << k;
    m_pay[k].aux   = $urandom;
  endtask

  task automatic refill(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[k] && !m_req[k]) begin
        m_req[k] = 1'b1;
        new_payload(k);
      end
    end
  endtask

  task automatic drive();
    rst_n = rst_req;
    for (int k = 0; k < N; k++) begin
      bus.data_req_i[k]              = m_req[k];
      bus.data_add_i[k*AW +: AW]     = m_pay[k].add;
      bus.data_wen_i[k]              = m_pay[k].wen;
      bus.data_wdata_i[k*DW +: DW]   = m_pay[k].wdata;
      bus.data_be_i[k*BW +: BW]      = m_pay[k].be;
      bus.data_ID_i[k*N +: N]        = m_pay[k].id;
      bus.data_aux_i[k*XW +: XW]     = m_pay[k].aux;
    end
    bus.data_gnt_i     = slv_gnt;
    bus.data_r_valid_i = rv;
    bus.data_r_ID_i    = rid;
  endtask

  // First eligible master scanning from the pointer with wrap-around.
  function automatic int model_winner();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (m_req[k] && m_cnt[k] < MAXO) return k;
    end
    return -1;
  endfunction

  function automatic bit any_req();
    for (int k = 0; k < N; k++) if (m_req[k]) return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle: drive at negedge, check master side at +1, update the model at +3
  // (the monitor handles the slave side at +2).
  task automatic step();
    int           w;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    bit           slot_free;
    @(negedge clk);
    drive();
    #1;
    w         = model_winner();
    slot_free = (exp_q.size() == 0) || slv_gnt;
    exp_gnt   = '0;
    if (rst_n && w >= 0 && slot_free) exp_gnt[w] = 1'b1;
    exp_rv = rv ? rid : '0;
    check("gnt_o", 64'(bus.data_gnt_o), 64'(exp_gnt));
    check("r_valid_o", 64'(bus.data_r_valid_o), 64'(exp_rv));
    check("err_o", 64'(err), 64'(m_err));
    #2;
    if (!rst_n) begin
      exp_q.delete();
      rfifo.delete();
      m_ptr = 0;
      m_err = 1'b0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (exp_gnt[k] && !exp_rv[k]) m_cnt[k]++;
        else if (exp_rv[k] && !exp_gnt[k]) begin
          if (m_cnt[k] == 0) m_err = 1'b1;
          else m_cnt[k]--;
        end
      end
      if (exp_gnt != '0) begin
        exp_q.push_back(m_pay[w]);
        glog.push_back(w);
        rfifo.push_back(w);
        m_ptr    = (w + 1) % N;
        m_req[w] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) m_req[k] = 1'b0;
    rv = 1'b0; rid = '0;
    rst_req = 1'b0;
    step();
    rst_req = 1'b1;
    glog.delete();
  endtask

  // Let holding masters finish and answer everything outstanding.
  task automatic drain();
    slv_gnt = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!any_req() && exp_q.size() == 0 && rfifo.size() == 0) break;
      if (rfifo.size() > 0) begin
        rv  = 1'b1;
        rid = N'(1) << rfifo.pop_front();
      end else begin
        rv  = 1'b0;
        rid = '0;
      end
      step();
    end
    rv  = 1'b0;
    rid = '0;
    check("drained", 64'(exp_q.size() + rfifo.size()), 64'(0));
  endtask

  task automatic check_glog(input string name, input int exp[$]);
    check({name, "_len"}, 64'(glog.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++) begin
      check(name, 64'(glog[i]), 64'(exp[i]));
    end
  endtask

  // Slave-side monitor: payload must match the oldest granted request for as long as it is shown.
  always @(negedge clk) begin
    #2;
    check("req_o", 64'(bus.data_req_o), 64'(exp_q.size() != 0));
    if (bus.data_req_o && exp_q.size() != 0) begin
      check("add_o", 64'(bus.data_add_o), 64'(exp_q[0].add));
      check("wen_o", 64'(bus.data_wen_o), 64'(exp_q[0].wen));
      check("wdata_o", 64'(bus.data_wdata_o), 64'(exp_q[0].wdata));
      check("be_o", 64'(bus.data_be_o), 64'(exp_q[0].be));
      check("ID_o", 64'(bus.data_ID_o), 64'(exp_q[0].id));
      check("aux_o", 64'(bus.data_aux_o), 64'(exp_q[0].aux));
      if (bus.data_gnt_i) begin
        void'(exp_q.pop_front());
        hs_cnt++;
      end
    end
  end

  initial begin
    int hs0;
    rst_req = 1'b0;
    slv_gnt = 1'b0;
    rv      = 1'b0;
    rid     = '0;
    m_ptr   = 0;
    m_err   = 1'b0;
    hs_cnt  = 0;
    for (int k = 0; k < N; k++) begin
      m_req[k] = 1'b0;
      m_cnt[k] = 0;
      new_payload(k);
    end
    drive();

    // Reset with all masters requesting: no grants, outputs cleared
    refill('1);
    slv_gnt = 1'b1;
    step();
    step();
    check("rst_req_o", 64'(bus.data_req_o), 64'(0));
    check("rst_add_o", 64'(bus.data_add_o), 64'(0));
    check("rst_wdata_o", 64'(bus.data_wdata_o), 64'(0));
    check("rst_be_o", 64'(bus.data_be_o), 64'(0));
    check("rst_ID_o", 64'(bus.data_ID_o), 64'(0));
    check("rst_aux_o", 64'(bus.data_aux_o), 64'(0));
    check("rst_err_o", 64'(err), 64'(0));

    // Continuous requests from all masters, slave always grants
    rst_req = 1'b1;
    glog.delete();
    hs0 = hs_cnt;
    for (int c = 0; c < 12; c++) begin
      refill('1);
      if (rfifo.size() > 0) begin rv = 1'b1; rid = N'(1) << rfifo.pop_front(); end
      else begin rv = 1'b0; rid = '0; end
      step();
    end
    rv = 1'b0; rid = '0;
    check_glog("rr_seq", '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1});
    check("rr_no_bubble", 64'(hs_cnt - hs0), 64'(11));
    drain();

    // Pointer wrap: master 4 alone, then masters 0 and 4
    do_reset();
    slv_gnt = 1'b1;
    refill(5'b10000);
    step();
    refill(5'b10001);
    step();
    refill(5'b10001);
    step();
    check_glog("wrap_seq", '{4, 0, 4});
    drain();

    // Slave stalls for 3 cycles with a loaded slot
    do_reset();
    slv_gnt = 1'b1;
    refill(5'b00100);
    step();
    slv_gnt = 1'b0;
    refill(5'b01000);
    hs0 = hs_cnt;
    repeat (3) step();
    check("stall_no_hs", 64'(hs_cnt - hs0), 64'(0));
    slv_gnt = 1'b1;
    step();
    check("stall_hs", 64'(hs_cnt - hs0), 64'(1));
    check_glog("stall_seq", '{2, 3});
    drain();

    // Outstanding limit on master 1
    do_reset();
    slv_gnt = 1'b1;
    repeat (4) begin refill(5'b00010); step(); end
    check_glog("limit_seq", '{1, 1});
    refill(5'b00010);
    rv = 1'b1; rid = 5'b00010;
    void'(rfifo.pop_front());
    step();
    rv = 1'b0; rid = '0;
    repeat (3) begin refill(5'b00010); step(); end
    check_glog("limit_seq2", '{1, 1, 1});
    drain();

    // Same-cycle grant and response for master 2
    do_reset();
    slv_gnt = 1'b1;
    refill(5'b00100);
    step();
    refill(5'b00100);
    rv = 1'b1; rid = 5'b00100;
    void'(rfifo.pop_front());
    step();
    rv = 1'b0; rid = '0;
    repeat (3) begin refill(5'b00100); step(); end
    check_glog("same_cyc_seq", '{2, 2, 2});
    drain();

    // Response to a master with nothing outstanding
    do_reset();
    rv = 1'b1; rid = 5'b01000;
    step();
    rv = 1'b0; rid = '0;
    step();
    check("err_set", 64'(err), 64'(1));
    step();
    check("err_sticky", 64'(err), 64'(1));
    rst_req = 1'b0;
    step();
    rst_req = 1'b1;
    step();
    check("err_cleared", 64'(err), 64'(0));

    // Randomised traffic with occasional resets
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      slv_gnt = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        if (!m_req[k] && $urandom_range(0, 2) == 0) refill(N'(1) << k);
      end
      if (rfifo.size() > 0 && $urandom_range(0, 1) == 1) begin
        int idx;
        idx = $urandom_range(0, rfifo.size() - 1);
        rv  = 1'b1;
        rid = N'(1) << rfifo[idx];
        rfifo.delete(idx);
      end else begin
        rv  = 1'b0;
        rid = '0;
      end
      rst_req = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_req = 1'b1;
    rv = 1'b0; rid = '0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/request_block_rr_bridge.md
# request_block_rr_bridge

N-master to one-slave request arbiter for the L2/TCDM bridge crossbar, the parametrised successor of the single-channel bridge request block. It adds three features: a fair round-robin arbiter that handles any N_MASTER with no power-of-two padding, an optional registered output slice, and per-master outstanding-transaction limiting. Responses are routed back to masters by one-hot ID. One instance sits in front of each bridge slave port.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, write-data width
- BE_WIDTH, DATA_WIDTH/8, byte-enable width
- AUX_WIDTH, 32, sideband width
- N_MASTER, 16, number of requesting masters (>=1, any value)
- ID_WIDTH, N_MASTER, one-hot master ID width (must equal N_MASTER)
- OUT_REG, 1, 0 = combinational pass-through, 1 = one-entry registered output slice
- MAX_OUTSTANDING, 4, maximum in-flight requests per master (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- data_req_i  in  N_MASTER  per-master request
- data_add_i  in  N_MASTER*ADDR_WIDTH  packed addresses
- data_wen_i  in  N_MASTER  write-enable (1 = read)
- data_wdata_i  in  N_MASTER*DATA_WIDTH  write data
- data_be_i  in  N_MASTER*BE_WIDTH  byte enables
- data_ID_i  in  N_MASTER*ID_WIDTH  one-hot IDs
- data_aux_i  in  N_MASTER*AUX_WIDTH  sideband
- data_gnt_o  out  N_MASTER  per-master grant, at most one bit set
- data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o, data_ID_o, data_aux_o  out  single-channel widths  slave-side request
- data_gnt_i  in  1  slave grant
- data_r_valid_i  in  1  slave response valid
- data_r_ID_i  in  ID_WIDTH  one-hot response ID
- data_r_valid_o  out  N_MASTER  routed response valid
- err_o  out  1  sticky: response received for a master with zero outstanding

## Operation
- Eligible master k: data_req_i[k] and cnt[k] < MAX_OUTSTANDING.
- Round-robin: search starts at ptr and wraps modulo N_MASTER. On an accepted handshake to k, ptr <= (k==N_MASTER-1) ? 0 : k+1. ptr holds when no handshake occurs.
- OUT_REG=0: data_req_o = any eligible. Outputs carry the winner's payload. data_gnt_o[k] = winner[k] & data_gnt_i.
- OUT_REG=1: slot free = !vld_q | data_gnt_i. data_gnt_o[k] = winner[k] & slot free. On a grant, the payload is loaded and vld_q <= 1. A slave grant with no load sets vld_q <= 0. data_req_o = vld_q. Payload is held stable while vld_q & !data_gnt_i.
- Outstanding counter cnt[k], width $clog2(MAX_OUTSTANDING+1):
  - +1 on data_gnt_o[k].
  - -1 on data_r_valid_o[k].
  - Both in the same cycle: unchanged.
- Every request, read or write, receives exactly one r_valid.
- data_r_valid_o[k] = data_r_valid_i & data_r_ID_i[k]. This path is combinational.
- Response to a master with cnt 0 and no simultaneous grant: cnt stays 0 and err_o <= 1 until reset.
- N_MASTER=1: the arbiter degenerates to a wire. ptr is constant 0.

## Timing
- Reset values:
  - ptr = 0, cnt = 0, vld_q = 0, err_o = 0.
  - data_req_o = 0. With OUT_REG=1, all registered payload outputs are 0.
  - data_gnt_o = 0 while rst_n = 0.
- Request latency: OUT_REG=0 gives 0 cycles. OUT_REG=1 gives 1 cycle from master grant to data_req_o.
- Throughput with OUT_REG=1 under a constantly granting slave: one request per cycle, no bubbles.
- Masters hold req and payload until granted. Grant is same-cycle and combinational from data_req_i (and from data_gnt_i).
- Reset mid-transaction discards vld_q and clears all counters. Responses arriving afterwards raise err_o.

## Structure
- Shared package bridge_interco_pkg:
  - default width constants (ADDR/DATA/AUX).
  - function cnt_width(max) = $clog2(max+1).
- Sub-module rr_arb_bridge, parameter N:
  - inputs req[N] and ptr; output one-hot gnt[N].
  - implemented with a double-width masked priority search.
  - pointer register stays in the parent.
- Payload mux is a one-hot AND-OR. There is no binary index decode on the data path.

## Test plan
- N_MASTER=3, OUT_REG=1, masters 0,1,2 request continuously, slave always grants → slave IDs 001,010,100,001,… with no idle cycles after the first.
- N_MASTER=5: only master 4 requests, then masters 0 and 4 request → ptr wraps 4→0; next grant goes to master 0 then master 4.
- OUT_REG=1, slave withholds data_gnt_i for 3 cycles → data_req_o and payload are stable, data_gnt_o=0 after the first load, and the transfer completes on the cycle data_gnt_i=1.
- MAX_OUTSTANDING=2, master 1 requests with no responses → two grants, then no further grant. A single r_valid with ID 00010 → exactly one more grant.
- Same-cycle grant and response to master 2 → cnt[2] unchanged, data_r_valid_o=00100.
- r_valid with ID 01000 while cnt[3]=0 → err_o rises the next cycle and stays high. rst_n low for one cycle → err_o=0.
